// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB TX scheduler: packet codes, state encoding,
// command payload and size clamping.
package usb_tx_pkg;

  localparam int unsigned PKT_CODE_W  = 2;
  localparam int unsigned SIZE_W      = 7;
  localparam int unsigned TIMER_W     = 8;
  localparam int unsigned MAX_PAYLOAD = 64;

  localparam logic [PKT_CODE_W-1:0] TXP_IDLE = 2'b00;
  localparam logic [PKT_CODE_W-1:0] TXP_DATA = 2'b01;
  localparam logic [PKT_CODE_W-1:0] TXP_ACK  = 2'b10;
  localparam logic [PKT_CODE_W-1:0] TXP_NACK = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DATA_HOLD
  } sched_state_e;

  // Latched command handed to the TX FSM.
  typedef struct packed {
    logic [PKT_CODE_W-1:0] code;
    logic [SIZE_W-1:0]     size;
  } tx_cmd_t;

  // Payload sizes above the USB full-speed bulk maximum are clamped.
  function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] size);
    return (size > SIZE_W'(MAX_PAYLOAD)) ? SIZE_W'(MAX_PAYLOAD) : size;
  endfunction

endpackage

// File: rtl/sched_timer.sv
// Clearable saturating cycle counter with terminal-count compare.
//  clk, n_rst : clock, async active-low reset
//  clr        : restart counting from 0 on the next edge
//  term       : terminal count value
//  tc_c       : combinational, high while count == term
module sched_timer
  import usb_tx_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clr,
  input  logic [TIMER_W-1:0] term,
  output logic               tc_c
);

  logic [TIMER_W-1:0] cnt;

  // Counter holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + TIMER_W'(1);
    end
  end

  assign tc_c = (cnt == term);

endmodule

// File: rtl/usb_tx_scheduler.sv
// USB TX scheduler: arbitrates handshake (ACK/NACK) and DATA requests onto the
// single TX packet path, holds the command while the TX FSM transmits, then
// enforces an inter-packet gap.
//  hs_req/hs_is_nack/hs_ack       : handshake request (level) and accept pulse
//  data_req/data_size/data_ack    : DATA request (level) and accept pulse
//  tx_packet/tx_packet_data_size  : command and latched payload size to the TX FSM
//  tx_busy                        : TX FSM transmitting
//  retry_req                      : host re-send request (USB_TX_RETRY_EN only)
//  sched_busy, tx_error, err_clear: status, sticky error, error clear
// Build option: define USB_TX_RETRY_EN to enable the DATA_HOLD retry window.
module usb_tx_scheduler
  import usb_tx_pkg::*;
#(
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned START_TIMEOUT = 32,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned RETRY_WINDOW  = 64
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  hs_req,
  input  logic                  hs_is_nack,
  output logic                  hs_ack,
  input  logic                  data_req,
  input  logic [SIZE_W-1:0]     data_size,
  output logic                  data_ack,
  output logic [PKT_CODE_W-1:0] tx_packet,
  output logic [SIZE_W-1:0]     tx_packet_data_size,
  input  logic                  tx_busy,
  input  logic                  retry_req,
  output logic                  sched_busy,
  output logic                  tx_error,
  input  logic                  err_clear
);

  sched_state_e          state_q, state_d;
  tx_cmd_t               cmd_q, cmd_d;
  logic [TIMER_W-1:0]    retry_q, retry_d;
  logic                  accept_hs_c, accept_data_c, set_err_c;
  logic                  timer_clr_c, timer_tc_c;
  logic [TIMER_W-1:0]    timer_term_c;
  logic                  hs_ack_d, data_ack_d, sched_busy_d, tx_error_d;
  logic [PKT_CODE_W-1:0] tx_packet_d;

  sched_timer u_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (timer_clr_c),
    .term  (timer_term_c),
    .tc_c  (timer_tc_c)
  );

  // Per-state terminal count for the shared timer.
  always_comb begin
    timer_term_c = '1;
    case (state_q)
      ST_ISSUE:     timer_term_c = TIMER_W'(START_TIMEOUT - 1);
      ST_GAP:       timer_term_c = TIMER_W'(GAP_CYCLES - 1);
`ifdef USB_TX_RETRY_EN
      ST_DATA_HOLD: timer_term_c = TIMER_W'(RETRY_WINDOW - 1);
`endif
      default:      ;
    endcase
  end

  // State, command latch and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      retry_q    <= '0;
      hs_ack     <= 1'b0;
      data_ack   <= 1'b0;
      tx_packet  <= TXP_IDLE;
      sched_busy <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      retry_q    <= retry_d;
      hs_ack     <= hs_ack_d;
      data_ack   <= data_ack_d;
      tx_packet  <= tx_packet_d;
      sched_busy <= sched_busy_d;
      tx_error   <= tx_error_d;
    end
  end

  // Next-state, arbitration and command latch.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    retry_d       = retry_q;
    accept_hs_c   = 1'b0;
    accept_data_c = 1'b0;
    set_err_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A stale transfer still on the wire blocks new issues.
        if (!tx_busy) begin
          if (hs_req) begin
            accept_hs_c = 1'b1;
            cmd_d.code  = hs_is_nack ? TXP_NACK : TXP_ACK;
            cmd_d.size  = '0;
            retry_d     = '0;
            state_d     = ST_ISSUE;
          end else if (data_req) begin
            accept_data_c = 1'b1;
            cmd_d.code    = TXP_DATA;
            cmd_d.size    = clamp_size(data_size);
            retry_d       = '0;
            state_d       = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_tc_c) begin
          set_err_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (timer_tc_c) begin
`ifdef USB_TX_RETRY_EN
          state_d = (cmd_q.code == TXP_DATA) ? ST_DATA_HOLD : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_DATA_HOLD: begin
`ifdef USB_TX_RETRY_EN
        if (retry_req) begin
          if (retry_q < TIMER_W'(MAX_RETRY)) begin
            retry_d = retry_q + TIMER_W'(1);
            state_d = ST_ISSUE;
          end else begin
            set_err_c = 1'b1;
            state_d   = ST_IDLE;
          end
        end else if (timer_tc_c) begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state; timer restarts on every state entry.
  always_comb begin
    hs_ack_d     = accept_hs_c;
    data_ack_d   = accept_data_c;
    tx_packet_d  = TXP_IDLE;
    sched_busy_d = (state_d != ST_IDLE);
    tx_error_d   = tx_error;
    timer_clr_c  = (state_d != state_q);
    if (state_d == ST_ISSUE || state_d == ST_WAIT_DONE) tx_packet_d = cmd_d.code;
    if (err_clear) tx_error_d = 1'b0;
    if (set_err_c) tx_error_d = 1'b1;
  end

  assign tx_packet_data_size = cmd_q.size;

`ifndef USB_TX_RETRY_EN
  logic unused_retry;
  assign unused_retry = ^{retry_req, TIMER_W'(MAX_RETRY), TIMER_W'(RETRY_WINDOW)};
`endif

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed self-checking bench for usb_tx_scheduler. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_usb_tx_scheduler;
  import usb_tx_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       hs_req, hs_is_nack, hs_ack;
  logic       data_req, data_ack;
  logic [6:0] data_size;
  logic [1:0] tx_packet;
  logic [6:0] tx_packet_data_size;
  logic       tx_busy, retry_req, sched_busy, tx_error, err_clear;

  int checks   = 0;
  int failures = 0;
  int n;

  // Clocks from GAP entry until sched_busy drops after a DATA packet.
`ifdef USB_TX_RETRY_EN
  localparam int DATA_TAIL = 80;
`else
  localparam int DATA_TAIL = 16;
`endif

  int sz_in  [5] = '{100, 0, 64, 65, 127};
  int sz_exp [5] = '{64,  0, 64, 64, 64};

  usb_tx_scheduler #(
    .GAP_CYCLES    (16),
    .START_TIMEOUT (32),
    .MAX_RETRY     (3),
    .RETRY_WINDOW  (64)
  ) dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .hs_req              (hs_req),
    .hs_is_nack          (hs_is_nack),
    .hs_ack              (hs_ack),
    .data_req            (data_req),
    .data_size           (data_size),
    .data_ack            (data_ack),
    .tx_packet           (tx_packet),
    .tx_packet_data_size (tx_packet_data_size),
    .tx_busy             (tx_busy),
    .retry_req           (retry_req),
    .sched_busy          (sched_busy),
    .tx_error            (tx_error),
    .err_clear           (err_clear)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // TX FSM stand-in: busy for 'hold' clocks, then drop and confirm GAP entry.
  task automatic tx_cycle(input int hold, input logic [1:0] code);
    tx_busy = 1'b1;
    step(hold);
    check_eq("tx_hold_code", 32'(tx_packet), 32'(code));
    tx_busy = 1'b0;
    step(1);
    check_eq("gap_code", 32'(tx_packet), 32'(TXP_IDLE));
    check_eq("gap_busy", 32'(sched_busy), 32'd1);
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (sched_busy && cnt < 300) begin
      step(1);
      cnt++;
    end
  endtask

  initial begin
    n_rst = 1'b0; hs_req = 1'b0; hs_is_nack = 1'b0; data_req = 1'b0;
    data_size = '0; tx_busy = 1'b0; retry_req = 1'b0; err_clear = 1'b0;
    step(2);
    check_eq("rst_tx_packet", 32'(tx_packet), 32'd0);
    check_eq("rst_size", 32'(tx_packet_data_size), 32'd0);
    check_eq("rst_busy", 32'(sched_busy), 32'd0);
    check_eq("rst_hs_ack", 32'(hs_ack), 32'd0);
    check_eq("rst_data_ack", 32'(data_ack), 32'd0);
    check_eq("rst_error", 32'(tx_error), 32'd0);
    n_rst = 1'b1;
    step(1);

    // ACK handshake, busy raised 3 clocks after ISSUE, held 40 clocks.
    hs_req = 1'b1; hs_is_nack = 1'b0;
    step(1);
    check_eq("ack_hs_ack", 32'(hs_ack), 32'd1);
    check_eq("ack_code", 32'(tx_packet), 32'(TXP_ACK));
    check_eq("ack_busy", 32'(sched_busy), 32'd1);
    hs_req = 1'b0;
    step(1);
    check_eq("ack_pulse", 32'(hs_ack), 32'd0);
    step(1);
    check_eq("ack_issue_hold", 32'(tx_packet), 32'(TXP_ACK));
    tx_cycle(40, TXP_ACK);
    wait_idle(n);
    check_eq("ack_gap_len", 32'(n), 32'd16);

    // Stale tx_busy in IDLE blocks acceptance.
    tx_busy = 1'b1; hs_req = 1'b1; hs_is_nack = 1'b1;
    step(3);
    check_eq("stale_no_ack", 32'(hs_ack), 32'd0);
    check_eq("stale_idle", 32'(sched_busy), 32'd0);
    tx_busy = 1'b0;
    step(1);
    check_eq("stale_ack", 32'(hs_ack), 32'd1);
    check_eq("nack_code", 32'(tx_packet), 32'(TXP_NACK));
    hs_req = 1'b0;
    tx_cycle(4, TXP_NACK);
    wait_idle(n);
    check_eq("nack_gap_len", 32'(n), 32'd16);

    // DATA size clamping and zero-length packets.
    for (int i = 0; i < 5; i++) begin
      data_req = 1'b1; data_size = 7'(sz_in[i]);
      step(1);
      check_eq("size_data_ack", 32'(data_ack), 32'd1);
      check_eq("size_code", 32'(tx_packet), 32'(TXP_DATA));
      check_eq("size_latched", 32'(tx_packet_data_size), 32'(sz_exp[i]));
      data_req = 1'b0;
      tx_cycle(3, TXP_DATA);
      wait_idle(n);
      check_eq("size_tail", 32'(n), 32'(DATA_TAIL));
    end

    // Simultaneous requests: handshake first, DATA only after GAP.
    hs_req = 1'b1; hs_is_nack = 1'b0; data_req = 1'b1; data_size = 7'd8;
    step(1);
    check_eq("arb_hs_ack", 32'(hs_ack), 32'd1);
    check_eq("arb_no_data_ack", 32'(data_ack), 32'd0);
    check_eq("arb_code", 32'(tx_packet), 32'(TXP_ACK));
    check_eq("arb_hs_size", 32'(tx_packet_data_size), 32'd0);
    hs_req = 1'b0;
    tx_cycle(5, TXP_ACK);
    n = 0;
    while (!data_ack && n < 100) begin
      step(1);
      n++;
    end
    check_eq("arb_data_delay", 32'(n), 32'd17);
    check_eq("arb_data_code", 32'(tx_packet), 32'(TXP_DATA));
    check_eq("arb_data_size", 32'(tx_packet_data_size), 32'd8);
    data_req = 1'b0;
    tx_cycle(6, TXP_DATA);
    wait_idle(n);
    check_eq("arb_tail", 32'(n), 32'(DATA_TAIL));

    // Start timeout: tx_busy never rises.
    hs_req = 1'b1;
    step(1);
    check_eq("to_hs_ack", 32'(hs_ack), 32'd1);
    hs_req = 1'b0;
    wait_idle(n);
    check_eq("to_len", 32'(n), 32'd32);
    check_eq("to_error", 32'(tx_error), 32'd1);
    check_eq("to_code", 32'(tx_packet), 32'(TXP_IDLE));
    step(3);
    check_eq("to_sticky", 32'(tx_error), 32'd1);
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    check_eq("to_cleared", 32'(tx_error), 32'd0);

    // Timeout with err_clear held high: the new error wins.
    hs_req = 1'b1; err_clear = 1'b1;
    step(1);
    hs_req = 1'b0;
    wait_idle(n);
    check_eq("win_len", 32'(n), 32'd32);
    check_eq("win_error", 32'(tx_error), 32'd1);
    err_clear = 1'b0;
    step(1);
    check_eq("win_sticky", 32'(tx_error), 32'd1);
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    check_eq("win_cleared", 32'(tx_error), 32'd0);

`ifdef USB_TX_RETRY_EN
    // Three honoured retries, the fourth exhausts the budget.
    data_req = 1'b1; data_size = 7'd4;
    step(1);
    check_eq("rt_data_ack", 32'(data_ack), 32'd1);
    check_eq("rt_size", 32'(tx_packet_data_size), 32'd4);
    data_req = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tx_cycle(5, TXP_DATA);
      step(16);
      check_eq("rt_hold_busy", 32'(sched_busy), 32'd1);
      step(10);
      retry_req = 1'b1;
      step(1);
      retry_req = 1'b0;
      check_eq("rt_reissue_code", 32'(tx_packet), 32'(TXP_DATA));
      check_eq("rt_reissue_size", 32'(tx_packet_data_size), 32'd4);
      check_eq("rt_no_data_ack", 32'(data_ack), 32'd0);
      check_eq("rt_no_error", 32'(tx_error), 32'd0);
    end
    tx_cycle(5, TXP_DATA);
    step(26);
    retry_req = 1'b1;
    step(1);
    retry_req = 1'b0;
    check_eq("rt_exhaust_error", 32'(tx_error), 32'd1);
    check_eq("rt_exhaust_idle", 32'(sched_busy), 32'd0);
    check_eq("rt_exhaust_code", 32'(tx_packet), 32'(TXP_IDLE));
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    check_eq("rt_cleared", 32'(tx_error), 32'd0);
`else
    // Without the retry build, retry_req has no effect.
    data_req = 1'b1; data_size = 7'd4;
    step(1);
    check_eq("nr_data_ack", 32'(data_ack), 32'd1);
    data_req = 1'b0;
    tx_cycle(5, TXP_DATA);
    wait_idle(n);
    check_eq("nr_tail", 32'(n), 32'd16);
    retry_req = 1'b1;
    step(1);
    retry_req = 1'b0;
    step(1);
    check_eq("nr_idle", 32'(sched_busy), 32'd0);
    check_eq("nr_code", 32'(tx_packet), 32'(TXP_IDLE));
    check_eq("nr_error", 32'(tx_error), 32'd0);
`endif

    // Asynchronous reset while in WAIT_DONE.
    data_req = 1'b1; data_size = 7'd20;
    step(1);
    check_eq("rs_data_ack", 32'(data_ack), 32'd1);
    check_eq("rs_size", 32'(tx_packet_data_size), 32'd20);
    data_req = 1'b0;
    tx_busy = 1'b1;
    step(3);
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("rs_async_code", 32'(tx_packet), 32'd0);
    check_eq("rs_async_busy", 32'(sched_busy), 32'd0);
    check_eq("rs_async_size", 32'(tx_packet_data_size), 32'd0);
    tx_busy = 1'b0;
    step(1);
    n_rst = 1'b1;
    step(1);
    hs_req = 1'b1; hs_is_nack = 1'b1;
    step(1);
    check_eq("rs_new_ack", 32'(hs_ack), 32'd1);
    check_eq("rs_new_code", 32'(tx_packet), 32'(TXP_NACK));
    hs_req = 1'b0;
    tx_cycle(4, TXP_NACK);
    wait_idle(n);
    check_eq("rs_gap_len", 32'(n), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
